// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for the shared ALU on the register bus.
// Each accepted command runs through these states:
//   read operand A, read operand B (binary ops only), execute, write back.
// Optional feature macro: ALU_ZFLAG_EN adds a registered zero flag output (z_flag).
module alu_sequencer #(
  parameter int WIDTH   = 16,
  parameter int SEL_W   = 3,
  parameter int BUS_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_src_a,
  input  logic [SEL_W-1:0] cmd_src_b,
  input  logic [SEL_W-1:0] cmd_dst,
  output logic [SEL_W-1:0] bus_sel,
  output logic             bus_rd,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_ei,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_eo,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             e_flag,
`ifdef ALU_ZFLAG_EN
  output logic             z_flag,
`endif
  output logic             done
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(BUS_LAT);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Unary opcodes (inc, dec, not) take only operand A.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd7);
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [2:0]         op_r;
  logic [SEL_W-1:0]   src_a_r;
  logic [SEL_W-1:0]   src_b_r;
  logic [SEL_W-1:0]   dst_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   result_r;
  logic               e_flag_r;
  logic [SEL_W-1:0]   bus_sel_r;
  logic [SEL_W-1:0]   bus_sel_next_s;
  logic               bus_rd_r;
  logic               wr_en_r;
  logic               done_r;
  logic               cmd_ready_r;
  logic               accept_s;
  logic               cnt_zero_s;

  assign accept_s   = cmd_valid && cmd_ready_r;
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  assign cmd_ready = cmd_ready_r;
  assign bus_sel   = bus_sel_r;
  assign bus_rd    = bus_rd_r;
  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_op    = op_r;
  assign alu_ei    = e_flag_r;
  assign wr_en     = wr_en_r;
  assign done      = done_r;
  assign wr_addr   = dst_r;
  assign wr_data   = result_r;
  assign e_flag    = e_flag_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and next bus select (read counter gates each operand read).
  always_comb begin
    state_next_s   = state_r;
    bus_sel_next_s = bus_sel_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s   = ST_RD_A;
          bus_sel_next_s = cmd_src_a;
        end else begin
          state_next_s   = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (cnt_zero_s) begin
          if (is_unary(op_r)) begin
            state_next_s   = ST_EXEC;
          end else begin
            state_next_s   = ST_RD_B;
            bus_sel_next_s = src_b_r;
          end
        end else begin
          state_next_s = ST_RD_A;
        end
      end
      ST_RD_B: begin
        if (cnt_zero_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_RD_B;
        end
      end
      ST_EXEC: state_next_s = ST_WB;
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Control outputs registered from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_sel_r   <= {SEL_W{1'b0}};
      bus_rd_r    <= 1'b0;
      wr_en_r     <= 1'b0;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      bus_sel_r   <= bus_sel_next_s;
      bus_rd_r    <= (state_next_s == ST_RD_A) || (state_next_s == ST_RD_B);
      wr_en_r     <= (state_next_s == ST_WB);
      done_r      <= (state_next_s == ST_WB);
      cmd_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Command latch, operand capture, wait counter, result and E flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= 3'd0;
      src_a_r  <= {SEL_W{1'b0}};
      src_b_r  <= {SEL_W{1'b0}};
      dst_r    <= {SEL_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      e_flag_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= cmd_op;
            src_a_r <= cmd_src_a;
            src_b_r <= cmd_src_b;
            dst_r   <= cmd_dst;
            cnt_r   <= LAT_LOAD;
            b_r     <= {WIDTH{1'b0}};  // stays zero for unary ops
          end
        end
        ST_RD_A: begin
          if (cnt_zero_s) begin
            a_r   <= bus_in;
            cnt_r <= LAT_LOAD;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_RD_B: begin
          if (cnt_zero_s) begin
            b_r <= bus_in;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        ST_EXEC: begin
          result_r <= alu_out;
          if (!op_r[2]) begin
            e_flag_r <= alu_eo;  // arithmetic ops only; logic ops keep E
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALU_ZFLAG_EN
  logic z_flag_r;
  assign z_flag = z_flag_r;

  // Zero flag captured with every result.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_flag_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      z_flag_r <= (alu_out == {WIDTH{1'b0}});
    end else begin
      z_flag_r <= z_flag_r;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one DUT with BUS_LAT=0, one with BUS_LAT=2,
// a shared register-file bus model and a reference ALU model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] rf [8];
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_src_a;
  logic [2:0]  cmd_src_b;
  logic [2:0]  cmd_dst;
  logic        cv0 = 1'b0;
  logic        cv2 = 1'b0;
  logic        sel2 = 1'b0;

  logic        ready0, rd0, ei0, eo0, wr0, e0, done0;
  logic [2:0]  bsel0, aop0, waddr0;
  logic [15:0] bin0, a0, b0, out0, wdata0;
  logic        ready2, rd2, ei2, eo2, wr2, e2, done2;
  logic [2:0]  bsel2, aop2, waddr2;
  logic [15:0] bin2, a2, b2, out2, wdata2;
`ifdef ALU_ZFLAG_EN
  logic        z0, z2;
`endif

  // Reference ALU: bit 16 is the E output (carry/borrow for arithmetic ops).
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a} + 17'd1;
      3'd3:    return {1'b0, a} - 17'd1;
      3'd4:    return {1'b0, a & b};
      3'd5:    return {1'b0, a | b};
      3'd6:    return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  assign bin0 = rf[bsel0];
  assign bin2 = rf[bsel2];
  assign {eo0, out0} = alu_f(aop0, a0, b0);
  assign {eo2, out2} = alu_f(aop2, a2, b2);

  alu_sequencer #(.WIDTH(16), .SEL_W(3), .BUS_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cv0), .cmd_ready(ready0), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .bus_sel(bsel0), .bus_rd(rd0), .bus_in(bin0), .alu_a(a0), .alu_b(b0),
    .alu_op(aop0), .alu_ei(ei0), .alu_out(out0), .alu_eo(eo0), .wr_en(wr0),
    .wr_addr(waddr0), .wr_data(wdata0), .e_flag(e0),
`ifdef ALU_ZFLAG_EN
    .z_flag(z0),
`endif
    .done(done0));

  alu_sequencer #(.WIDTH(16), .SEL_W(3), .BUS_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cv2), .cmd_ready(ready2), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .bus_sel(bsel2), .bus_rd(rd2), .bus_in(bin2), .alu_a(a2), .alu_b(b2),
    .alu_op(aop2), .alu_ei(ei2), .alu_out(out2), .alu_eo(eo2), .wr_en(wr2),
    .wr_addr(waddr2), .wr_data(wdata2), .e_flag(e2),
`ifdef ALU_ZFLAG_EN
    .z_flag(z2),
`endif
    .done(done2));

  // Observation mux: sel2 picks which DUT the common tasks look at.
  logic        m_ready, m_rd, m_wr, m_e, m_done;
  logic [2:0]  m_bsel, m_waddr;
  logic [15:0] m_wdata;
  assign m_ready = sel2 ? ready2 : ready0;
  assign m_rd    = sel2 ? rd2    : rd0;
  assign m_wr    = sel2 ? wr2    : wr0;
  assign m_e     = sel2 ? e2     : e0;
  assign m_done  = sel2 ? done2  : done0;
  assign m_bsel  = sel2 ? bsel2  : bsel0;
  assign m_waddr = sel2 ? waddr2 : waddr0;
  assign m_wdata = sel2 ? wdata2 : wdata0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, measure accept-to-wr_en latency and operand read cycles.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [2:0] dst, input logic [15:0] exp_d,
                        input logic exp_e, input int exp_lat, input int exp_rda, input int exp_rdb);
    int n;
    int rda;
    int rdb;
    bit seen;
    @(negedge clk);
    check_eq({tag, "_ready_before"}, m_ready, 1);
    cmd_op = op; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = dst;
    if (sel2) cv2 = 1'b1; else cv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cv0 = 1'b0; cv2 = 1'b0;
    n = 1; seen = 1'b0; rda = 0; rdb = 0;
    while (!seen && n <= 40) begin
      if (m_rd && m_bsel == sa) rda++;
      if (m_rd && m_bsel == sb) rdb++;
      if (m_wr) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq({tag, "_wr_seen"}, seen, 1);
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_wr_data"}, m_wdata, exp_d);
    check_eq({tag, "_wr_addr"}, m_waddr, dst);
    check_eq({tag, "_done"}, m_done, 1);
    check_eq({tag, "_e_flag"}, m_e, exp_e);
    check_eq({tag, "_rd_a_cycles"}, rda, exp_rda);
    check_eq({tag, "_rd_b_cycles"}, rdb, exp_rdb);
    @(negedge clk);
    check_eq({tag, "_wr_one_cycle"}, m_wr, 0);
    check_eq({tag, "_ready_after"}, m_ready, 1);
  endtask

  initial begin
    int acc;
    int wrs;
    int second;
    int bad;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    cmd_op = 3'd0; cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_dst = 3'd0;
    rf[0] = 16'h00FF; rf[1] = 16'h0003; rf[2] = 16'h0004; rf[3] = 16'h0000;
    rf[4] = 16'h0001; rf[5] = 16'hF0F0; rf[6] = 16'h3C3C; rf[7] = 16'hFFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_cmd_ready", ready0, 1);
    check_eq("rst_bus_rd", rd0, 0);
    check_eq("rst_wr_en", wr0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_e_flag", e0, 0);
    check_eq("rst_bus_sel", bsel0, 0);
    check_eq("rst_alu_a", a0, 0);
    check_eq("rst_alu_b", b0, 0);
    check_eq("rst_alu_op", aop0, 0);
    check_eq("rst_wr_data", wdata0, 0);
    check_eq("rst_wr_addr", waddr0, 0);

    // T1: 3 + 4 = 7, no carry.
    do_cmd("t1_add", 3'd0, 3'd1, 3'd2, 3'd5, 16'h0007, 1'b0, 4, 1, 1);
    // T2: 0 - 1 = 0xFFFF with borrow.
    do_cmd("t2_sub", 3'd1, 3'd3, 3'd4, 3'd6, 16'hFFFF, 1'b1, 4, 1, 1);
    // T3: not 0x00FF, src_b=7 never read, E kept from T2.
    do_cmd("t3_not", 3'd7, 3'd0, 3'd7, 3'd1, 16'hFF00, 1'b1, 3, 1, 0);
    check_eq("t3_alu_b_zero", b0, 0);

    // T4: cmd_valid held high across a full command.
    @(negedge clk);
    cmd_op = 3'd0; cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd3;
    cv0 = 1'b1;
    acc = 0; wrs = 0; second = -1;
    for (int i = 0; i < 9; i++) begin
      if (ready0) begin
        acc++;
        if (i > 0) second = i;
      end
      if (wr0) wrs++;
      @(negedge clk);
    end
    cv0 = 1'b0;
    check_eq("t4_accepts", acc, 2);
    check_eq("t4_second_accept_idx", second, 5);
    check_eq("t4_single_write", wrs, 1);
    check_eq("t4_second_wr", wr0, 1);
    check_eq("t4_second_data", wdata0, 16'h0007);
    @(negedge clk);

    // T5: BUS_LAT=2, and 0xF0F0 & 0x3C3C.
    sel2 = 1'b1;
    do_cmd("t5_and_lat2", 3'd4, 3'd5, 3'd6, 3'd2, 16'h3030, 1'b0, 8, 3, 3);
    sel2 = 1'b0;

    // T6: reset pulsed while dut0 is in EXEC of inc 0xFFFF (would set E).
    @(negedge clk);
    cmd_op = 3'd2; cmd_src_a = 3'd7; cmd_src_b = 3'd0; cmd_dst = 3'd3;
    cv0 = 1'b1;
    bad = 0;
    @(posedge clk);
    @(negedge clk);
    cv0 = 1'b0;
    if (wr0 || done0) bad++;
    @(negedge clk);
    rst = 1'b1;
    if (wr0 || done0) bad++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_e_flag_cleared", e0, 0);
    check_eq("t6_ready", ready0, 1);
    for (int i = 0; i < 5; i++) begin
      if (wr0 || done0) bad++;
      @(negedge clk);
    end
    check_eq("t6_no_write", bad, 0);
    do_cmd("t6_after", 3'd0, 3'd7, 3'd1, 3'd4, 16'h0002, 1'b1, 4, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
